btn_debounce: RTL and testbench

//  Debounces N raw active-low push-buttons from the board pins and emits clean levels

---
 rtl/board_pkg.sv | 25 ++
 rtl/btn_channel.sv | 147 ++++++++++++++
 rtl/btn_debounce.sv | 47 ++++
 tb/tb_btn_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and board-level constants for the push-button debouncer.
// Used by btn_channel and btn_debounce.
package board_pkg;

    typedef enum logic [1:0] {
        BTN_UP      = 2'd0,
        BTN_WAIT_DN = 2'd1,
        BTN_DOWN    = 2'd2,
        BTN_WAIT_UP = 2'd3
    } btn_state_t;

    // 1 ms settle window at 50 MHz; repeat timings are 0.5 s and 0.1 s.
    localparam int DB_CYCLES_50MHZ  = 50000;
    localparam int REP_DELAY_50MHZ  = 25000000;
    localparam int REP_PERIOD_50MHZ = 5000000;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            max_int = a;
        end else begin
            max_int = b;
        end
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One debounced button: 2-flop synchroniser, UP/WAIT_DN/DOWN/WAIT_UP FSM, strobes.
// Optional hold-to-repeat PRESS when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_channel
    import board_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_50MHZ
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY  = REP_DELAY_50MHZ,
    parameter int REP_PERIOD = REP_PERIOD_50MHZ
`endif
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int              CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_rep_fire;

    // Two-flop synchroniser on the inverted pin; reset value means released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~i_btn_raw_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int               HOLD_W   = $clog2(max_int(REP_DELAY, REP_PERIOD));
    localparam logic [HOLD_W-1:0] DLY_TERM = HOLD_W'(REP_DELAY - 1);
    localparam logic [HOLD_W-1:0] PER_TERM = HOLD_W'(REP_PERIOD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_rep_phase;

    // The first repeat waits REP_DELAY, later ones REP_PERIOD; any exit from DOWN starts over.
    assign w_rep_fire = (r_state == BTN_DOWN) && r_sync2 &&
                        (r_hold == (r_rep_phase ? PER_TERM : DLY_TERM));

    // Hold counter: runs only while the button sits stably in DOWN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= HOLD_W'(0);
            r_rep_phase <= 1'b0;
        end else if ((r_state != BTN_DOWN) || !r_sync2) begin
            r_hold      <= HOLD_W'(0);
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_hold      <= HOLD_W'(0);
            r_rep_phase <= 1'b1;
        end else begin
            r_hold      <= r_hold + HOLD_W'(1);
            r_rep_phase <= r_rep_phase;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Debounce FSM with registered level and strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= BTN_UP;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                BTN_UP: begin
                    if (r_sync2) begin
                        r_state <= BTN_WAIT_DN;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_state <= BTN_UP;
                        r_cnt   <= r_cnt;
                    end
                end
                BTN_WAIT_DN: begin
                    if (!r_sync2) begin
                        r_state <= BTN_UP;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == CNT_TERM) begin
                        r_state <= BTN_DOWN;
                        r_cnt   <= CNT_ZERO;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                BTN_DOWN: begin
                    if (!r_sync2) begin
                        r_state <= BTN_WAIT_UP;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_state <= BTN_DOWN;
                        r_press <= w_rep_fire;
                    end
                end
                BTN_WAIT_UP: begin
                    if (r_sync2) begin
                        r_state <= BTN_DOWN;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == CNT_TERM) begin
                        r_state   <= BTN_UP;
                        r_cnt     <= CNT_ZERO;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= BTN_UP;
                    r_cnt   <= CNT_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// N-channel push-button debouncer: one btn_channel per pin plus ANY_PRESS.
// Auto-repeat of PRESS while held is built only with BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
    import board_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int DB_CYCLES  = DB_CYCLES_50MHZ
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY  = REP_DELAY_50MHZ,
    parameter int REP_PERIOD = REP_PERIOD_50MHZ
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn_raw_n,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic             o_any_press
);

    logic [N_BTN-1:0] w_press;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DB_CYCLES  (DB_CYCLES)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            ,
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
`endif
        ) u_chan (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_btn_raw_n (i_btn_raw_n[g]),
            .o_level     (o_level[g]),
            .o_press     (w_press[g]),
            .o_release   (o_release[g])
        );
    end

    // Press strobes are already registered per channel, so the OR stays single-cycle.
    assign o_press     = w_press;
    assign o_any_press = |w_press;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed table-driven bench for btn_debounce (DB_CYCLES=8, REP_DELAY=20, REP_PERIOD=6).
// Repeat expectations switch on BTN_DEBOUNCE_AUTOREPEAT_EN.
module tb_btn_debounce;

    localparam int N_BTN = 2;
    localparam int DB    = 8;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int RDLY  = 20;
    localparam int RPER  = 6;
`endif

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] pins;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic             any;

    int n_vec;
    int n_err;

    btn_debounce #(
        .N_BTN      (N_BTN),
        .DB_CYCLES  (DB)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        ,
        .REP_DELAY  (RDLY),
        .REP_PERIOD (RPER)
`endif
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_raw_n (pins),
        .o_level     (level),
        .o_press     (press),
        .o_release   (rel),
        .o_any_press (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] pins;
        int         ncyc;
        logic [1:0] mid_lvl;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rls;
        logic       anyp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input logic [1:0] p, input int n,
                                input logic [1:0] ml, input logic [1:0] l,
                                input logic [1:0] pr, input logic [1:0] rl, input logic a);
        vec_t v;
        v.name = nm; v.pins = p; v.ncyc = n; v.mid_lvl = ml;
        v.lvl = l; v.prs = pr; v.rls = rl; v.anyp = a;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive pins, advance ncyc cycles; intermediate cycles must be strobe-free at mid_lvl.
    task automatic run_vec(input vec_t v);
        logic bad;
        bad = 1'b0;
        pins = v.pins;
        for (int i = 1; i <= v.ncyc; i++) begin
            step();
            if (i < v.ncyc) begin
                if ((press != 2'b00) || (rel != 2'b00) || (any != 1'b0) || (level != v.mid_lvl)) begin
                    if (!bad) begin
                        $display("FAIL %s (cycle %0d): level=%b press=%b release=%b any=%b, required level=%b and no strobes",
                                 v.name, i, level, press, rel, any, v.mid_lvl);
                    end
                    bad = 1'b1;
                end
            end else begin
                if ((level != v.lvl) || (press != v.prs) || (rel != v.rls) || (any != v.anyp)) begin
                    $display("FAIL %s (cycle %0d): level=%b press=%b release=%b any=%b, required level=%b press=%b release=%b any=%b",
                             v.name, i, level, press, rel, any, v.lvl, v.prs, v.rls, v.anyp);
                    bad = 1'b1;
                end
            end
        end
        n_vec++;
        if (bad) n_err++;
    endtask

    task automatic check_idle(input string nm);
        n_vec++;
        if ((level != 2'b00) || (press != 2'b00) || (rel != 2'b00) || (any != 1'b0)) begin
            $display("FAIL %s: level=%b press=%b release=%b any=%b, required all zero",
                     nm, level, press, rel, any);
            n_err++;
        end
    endtask

    initial begin
        vec_t v;
        logic bad;
        logic exp_p;

        n_vec = 0;
        n_err = 0;

        add("rst_held_press",     2'b10, DB+2, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1);
        add("rst_press_single",   2'b10, 1,    2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        add("rst_release",        2'b11, DB+2, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
        add("idle",               2'b11, 1,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add("clean_press",        2'b10, DB+2, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1);
        add("clean_press_single", 2'b10, 1,    2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        add("clean_release",      2'b11, DB+2, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
        add("clean_idle",         2'b11, 3,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        for (int j = 0; j < 5; j++) begin
            add("bounce_lo",      2'b10, 3,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            add("bounce_hi",      2'b11, 3,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        add("bounce_press",       2'b10, DB+2, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1);
        add("bounce_single",      2'b10, 1,    2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        add("bounce_release",     2'b11, DB+2, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
        add("glitch",             2'b10, 5,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add("glitch_after",       2'b11, 15,   2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add("ch1_press",          2'b01, DB+2, 2'b00, 2'b10, 2'b10, 2'b00, 1'b1);
        add("ch1_release",        2'b11, DB+2, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        add("both_press",         2'b00, DB+2, 2'b00, 2'b11, 2'b11, 2'b00, 1'b1);
        add("both_single",        2'b00, 1,    2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        add("both_release",       2'b11, DB+2, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0);
        add("both_idle",          2'b11, 2,    2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // Reset held with ch0 pressed: outputs stay zero.
        rst_n = 1'b0;
        pins  = 2'b10;
        repeat (4) step();
        check_idle("reset_hold");
        rst_n = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k]);

        // Reset asserted while both channels are in WAIT_DN: no strobe, level stays 0.
        bad  = 1'b0;
        pins = 2'b00;
        repeat (6) begin
            step();
            if ((press != 2'b00) || (level != 2'b00)) bad = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        if ((level != 2'b00) || (press != 2'b00) || (rel != 2'b00) || (any != 1'b0)) bad = 1'b1;
        pins = 2'b11;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (15) begin
            step();
            if ((level != 2'b00) || (press != 2'b00) || (rel != 2'b00) || (any != 1'b0)) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            $display("FAIL rst_mid_debounce: level=%b press=%b release=%b any=%b, required no strobes and level 00",
                     level, press, rel, any);
            n_err++;
        end

        // Long hold on ch0: repeats only with the auto-repeat build.
        v.name = "hold_press"; v.pins = 2'b10; v.ncyc = DB + 2; v.mid_lvl = 2'b00;
        v.lvl = 2'b01; v.prs = 2'b01; v.rls = 2'b00; v.anyp = 1'b1;
        run_vec(v);
        bad = 1'b0;
        for (int i = 1; i <= 58; i++) begin
            step();
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            exp_p = (i >= RDLY) && (((i - RDLY) % RPER) == 0);
`else
            exp_p = 1'b0;
`endif
            if ((press[0] != exp_p) || (press[1] != 1'b0) || (any != exp_p) ||
                (rel != 2'b00) || (level != 2'b01)) begin
                if (!bad) begin
                    $display("FAIL hold_repeat (cycle %0d): level=%b press=%b release=%b any=%b, required level=01 press[0]=%b",
                             i, level, press, rel, any, exp_p);
                end
                bad = 1'b1;
            end
        end
        n_vec++;
        if (bad) n_err++;
        v.name = "hold_release"; v.pins = 2'b11; v.ncyc = DB + 2; v.mid_lvl = 2'b01;
        v.lvl = 2'b00; v.prs = 2'b00; v.rls = 2'b01; v.anyp = 1'b0;
        run_vec(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
